// File: rtl/fifo_put_arbiter.sv
// rtl/fifo_put_arbiter.sv - round-robin arbiter sharing one 4-phase FIFO put port among producers
//
// Each producer runs its own 4-phase req/ack handshake with this block. One
// word is forwarded to the FIFO per grant. Grants rotate round-robin, so the
// producer served last has the lowest priority in the next arbitration.
//
// Optional feature: define FIFO_PUT_ARBITER_STATS_EN to add a saturating
// 16-bit transfer_count output. Without the macro, that port does not exist.
//
// Ports:
//   clock           single clock; all state changes on posedge
//   clear_n         asynchronous active-low reset
//   src_put_req     per-producer request level
//   src_put_ack     per-producer ack level (at most one bit high)
//   src_put_value   flat bus; producer i at [i*WORD_SIZE +: WORD_SIZE]
//   fifo_put_req    to FIFO put_req
//   fifo_put_ack    from FIFO put_ack (one-cycle pulse)
//   fifo_put_value  to FIFO put_value, held stable while fifo_put_req is high
//   grant_index     producer currently being served
//   busy            high whenever a transfer is in progress (state != ARB)
//   transfer_count  (stats build only) number of words accepted by the FIFO
module fifo_put_arbiter #(
  parameter int REQUESTER_COUNT = 4,
  parameter int WORD_SIZE       = 1,
  localparam int GRANT_BITS     = $clog2(REQUESTER_COUNT)
) (
  input  logic                                 clock,
  input  logic                                 clear_n,
  input  logic [REQUESTER_COUNT-1:0]           src_put_req,
  output logic [REQUESTER_COUNT-1:0]           src_put_ack,
  input  logic [REQUESTER_COUNT*WORD_SIZE-1:0] src_put_value,
  output logic                                 fifo_put_req,
  input  logic                                 fifo_put_ack,
  output logic [WORD_SIZE-1:0]                 fifo_put_value,
  output logic [GRANT_BITS-1:0]                grant_index,
  output logic                                 busy
`ifdef FIFO_PUT_ARBITER_STATS_EN
  ,
  output logic [15:0]                          transfer_count
`endif
);

  typedef enum logic [1:0] {
    ARB              = 2'd0,
    PUT_WAIT_ACK     = 2'd1,
    SRC_WAIT_REQ_LOW = 2'd2
  } state_t;

  state_t                       state, state_nx;
  logic [GRANT_BITS-1:0]        last_grant, last_grant_nx;
  logic [GRANT_BITS-1:0]        grant_index_nx;
  logic [REQUESTER_COUNT-1:0]   src_put_ack_nx;
  logic                         fifo_put_req_nx;
  logic [WORD_SIZE-1:0]         fifo_put_value_nx;

  // Round-robin search result: first requester after last_grant, wrapping.
  logic                         found;
  logic [GRANT_BITS-1:0]        pick;
  logic [GRANT_BITS-1:0]        cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= REQUESTER_COUNT; k++) begin
      cand = GRANT_BITS'((int'(last_grant) + k) % REQUESTER_COUNT);
      if (!found && src_put_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nx          = state;
    last_grant_nx     = last_grant;
    grant_index_nx    = grant_index;
    src_put_ack_nx    = src_put_ack;
    fifo_put_req_nx   = fifo_put_req;
    fifo_put_value_nx = fifo_put_value;
    case (state)
      ARB: begin
        if (found) begin
          fifo_put_value_nx = src_put_value[int'(pick)*WORD_SIZE +: WORD_SIZE];
          grant_index_nx    = pick;
          fifo_put_req_nx   = 1'b1;
          state_nx          = PUT_WAIT_ACK;
        end
      end
      PUT_WAIT_ACK: begin
        // No timeout: a full FIFO simply stalls the current producer.
        if (fifo_put_ack) begin
          fifo_put_req_nx             = 1'b0;
          src_put_ack_nx[grant_index] = 1'b1;
          state_nx                    = SRC_WAIT_REQ_LOW;
        end
      end
      SRC_WAIT_REQ_LOW: begin
        // A producer holding its request keeps its ack and gets no second word.
        if (!src_put_req[grant_index]) begin
          src_put_ack_nx[grant_index] = 1'b0;
          last_grant_nx               = grant_index;
          state_nx                    = ARB;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state          <= ARB;
      last_grant     <= GRANT_BITS'(REQUESTER_COUNT - 1);
      grant_index    <= '0;
      src_put_ack    <= '0;
      fifo_put_req   <= 1'b0;
      fifo_put_value <= '0;
    end else begin
      state          <= state_nx;
      last_grant     <= last_grant_nx;
      grant_index    <= grant_index_nx;
      src_put_ack    <= src_put_ack_nx;
      fifo_put_req   <= fifo_put_req_nx;
      fifo_put_value <= fifo_put_value_nx;
    end
  end

  assign busy = (state != ARB);

`ifdef FIFO_PUT_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      transfer_count <= '0;
    end else if (state == PUT_WAIT_ACK && fifo_put_ack && transfer_count != 16'hFFFF) begin
      transfer_count <= transfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// tb/tb_fifo_put_arbiter.sv - self-checking bench for fifo_put_arbiter
module tb_fifo_put_arbiter;
  localparam int N     = 4;
  localparam int WS    = 8;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              clear_n = 1'b0;
  logic [N-1:0]      src_put_req;
  logic [N-1:0]      src_put_ack;
  logic [N*WS-1:0]   src_put_value;
  logic              fifo_put_req;
  logic              fifo_put_ack;
  logic [WS-1:0]     fifo_put_value;
  logic [1:0]        grant_index;
  logic              busy;
`ifdef FIFO_PUT_ARBITER_STATS_EN
  logic [15:0]       transfer_count;
`endif

  fifo_put_arbiter #(.REQUESTER_COUNT(N), .WORD_SIZE(WS)) dut (
    .clock(clock), .clear_n(clear_n),
    .src_put_req(src_put_req), .src_put_ack(src_put_ack), .src_put_value(src_put_value),
    .fifo_put_req(fifo_put_req), .fifo_put_ack(fifo_put_ack), .fifo_put_value(fifo_put_value),
    .grant_index(grant_index), .busy(busy)
`ifdef FIFO_PUT_ARBITER_STATS_EN
    , .transfer_count(transfer_count)
`endif
  );

  always #5 clock = ~clock;

  // Producer drive
  logic [N-1:0]  p_req = '0;
  logic [WS-1:0] p_val [N];
  assign src_put_req = p_req;
  always_comb begin
    src_put_value = '0;
    for (int i = 0; i < N; i++) src_put_value[i*WS +: WS] = p_val[i];
  end

  // Behavioural FIFO put side: acks one cycle after seeing a request, if not full
  logic          f_ack = 1'b0;
  logic [WS-1:0] fq[$];
  int            fstate = 0;
  bit            armed = 1'b0;
  assign fifo_put_ack = f_ack;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model: transaction-level view of the handshake
  bit           m_req = 1'b0;
  logic [N-1:0] m_ack = '0;
  int           m_gi = 0;
  int           m_last = N - 1;
  logic [WS-1:0] m_val = '0;
  int           m_count = 0;
  int           grant_log[$];

  always @(negedge clock) begin
    if (!clear_n) begin
      m_req = 1'b0; m_ack = '0; m_gi = 0; m_last = N - 1; m_val = '0; m_count = 0;
      check("reset_outputs", {src_put_ack, fifo_put_req, fifo_put_value, grant_index, busy}, '0);
    end else begin
      if (!m_req && m_ack == '0) begin
        int g;
        g = rr(src_put_req, m_last);
        if (g >= 0) begin
          m_req = 1'b1; m_gi = g; m_val = src_put_value[g*WS +: WS];
          grant_log.push_back(g);
        end
      end else if (m_req) begin
        if (fifo_put_ack) begin
          m_req = 1'b0;
          m_ack = N'(1) << m_gi;
          if (m_count < 65535) m_count++;
        end
      end else if (!src_put_req[m_gi]) begin
        m_ack = '0;
        m_last = m_gi;
      end
      check("fifo_put_req", fifo_put_req, m_req);
      check("src_put_ack", src_put_ack, m_ack);
      check("grant_index", grant_index, m_gi);
      check("fifo_put_value", fifo_put_value, m_val);
      check("busy", busy, m_req || m_ack != '0);
      check("ack_onehot0", $onehot0(src_put_ack), 1);
      check("ack_while_req", fifo_put_req && (src_put_ack != '0), 0);
`ifdef FIFO_PUT_ARBITER_STATS_EN
      check("transfer_count", transfer_count, m_count);
`endif
    end
  end

  task automatic fifo_update();
    if (!clear_n) begin
      fq.delete(); fstate = 0; armed = 1'b0; f_ack = 1'b0;
      return;
    end
    f_ack = 1'b0;
    if (fstate == 0) begin
      if (fifo_put_req) begin
        if (armed && fq.size() < DEPTH) begin
          f_ack = 1'b1; fq.push_back(fifo_put_value); fstate = 1; armed = 1'b0;
        end else begin
          armed = 1'b1;
        end
      end
    end else if (!fifo_put_req) begin
      fstate = 0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
    fifo_update();
  endtask

  task automatic wait_grant(string name);
    for (int t = 0; t < 20; t++) begin
      tick();
      if (fifo_put_req) return;
    end
    check({name, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_ack(string name, int i, output int cycles);
    cycles = 0;
    for (int t = 0; t < 30; t++) begin
      if (src_put_ack[i]) return;
      tick();
      cycles++;
    end
    check({name, "_ack_timeout"}, 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (p_req == '0 && !busy) break;
      for (int i = 0; i < N; i++) if (p_req[i] && src_put_ack[i]) p_req[i] = 1'b0;
      if (fq.size() > 0) void'(fq.pop_front());
      tick();
    end
    check("drain_idle", {p_req, busy}, '0);
  endtask

  initial begin
    int cyc;
    int cnt;
    logic [WS-1:0] popped;
    bit [N-1:0] rearm;
    for (int i = 0; i < N; i++) p_val[i] = '0;

    // Reset state
    repeat (3) tick();
    check("rst_req", fifo_put_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", src_put_ack, 0);
    clear_n = 1'b1;
    tick();

    // 1: single producer 2 sends A5
    p_val[2] = 8'hA5; p_req[2] = 1'b1;
    wait_grant("t1");
    check("t1_grant", grant_index, 2);
    check("t1_value", fifo_put_value, 8'hA5);
    wait_ack("t1", 2, cyc);
    check("t1_ack_latency", cyc, 2);
    p_req[2] = 1'b0;
    repeat (2) tick();
    check("t1_fifo_count", fq.size(), 1);
    popped = fq.pop_front();
    check("t1_get_value", popped, 8'hA5);

    // 2: all requests high from reset, round-robin order
    clear_n = 1'b0;
    for (int i = 0; i < N; i++) p_val[i] = WS'(8'h10 + i);
    p_req = '1;
    rearm = '0;
    tick();
    clear_n = 1'b1;
    grant_log.delete();
    for (int t = 0; t < 40; t++) begin
      tick();
      if (fq.size() > 0) void'(fq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (p_req[i] && src_put_ack[i]) begin p_req[i] = 1'b0; rearm[i] = 1'b1; end
        else if (rearm[i]) begin p_req[i] = 1'b1; rearm[i] = 1'b0; end
      end
    end
    check("t2_log_len_ge6", grant_log.size() >= 6, 1);
    if (grant_log.size() >= 6) begin
      check("t2_order0", grant_log[0], 0);
      check("t2_order1", grant_log[1], 1);
      check("t2_order2", grant_log[2], 2);
      check("t2_order3", grant_log[3], 3);
      check("t2_order4", grant_log[4], 0);
      check("t2_order5", grant_log[5], 1);
      for (int j = 1; j < 6; j++) check("t2_no_repeat", grant_log[j] == grant_log[j-1], 0);
    end
    drain();
    fq.delete();

    // 3: FIFO full, producer 1 stalls until a get
    for (int i = 0; i < DEPTH; i++) fq.push_back(WS'(i));
    p_val[1] = 8'h3C; p_req[1] = 1'b1;
    wait_grant("t3");
    repeat (8) begin
      tick();
      check("t3_stall", {fifo_put_req, busy, src_put_ack}, {1'b1, 1'b1, 4'b0000});
    end
    void'(fq.pop_front());
    wait_ack("t3", 1, cyc);
    check("t3_count", fq.size(), DEPTH);
    check("t3_value", fq[DEPTH-1], 8'h3C);
    p_req[1] = 1'b0;
    repeat (2) tick();
    fq.delete();

    // 4: producer 0 holds request after ack
    p_val[0] = 8'h5A; p_req[0] = 1'b1;
    wait_grant("t4");
    wait_ack("t4", 0, cyc);
    cnt = fq.size();
    check("t4_pushed", cnt, 1);
    repeat (10) begin
      tick();
      check("t4_ack_held", src_put_ack, 4'b0001);
      check("t4_no_second_push", fq.size(), cnt);
    end
    p_req[0] = 1'b0;
    repeat (2) tick();
    check("t4_ack_released", src_put_ack, 0);
    fq.delete();

    // 5: asynchronous reset while waiting for the FIFO ack
    for (int i = 0; i < DEPTH; i++) fq.push_back(WS'(i));
    p_val[1] = 8'h77; p_req[1] = 1'b1;
    wait_grant("t5");
    repeat (2) tick();
    check("t5_pre_req", fifo_put_req, 1);
    #2;
    clear_n = 1'b0;
    #1;
    check("t5_async_clear", {src_put_ack, fifo_put_req, fifo_put_value, grant_index, busy}, '0);
    p_req = '0;
    tick();
    clear_n = 1'b1;
    p_val[0] = 8'hC0; p_val[3] = 8'hC3;
    p_req = 4'b1001;
    wait_grant("t5b");
    check("t5_priority0", grant_index, 0);
    drain();

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      tick();
      if (fq.size() > 0 && $urandom_range(0, 2) == 0) void'(fq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (p_req[i]) begin
          if (src_put_ack[i] && $urandom_range(0, 2) == 0) p_req[i] = 1'b0;
        end else if (!src_put_ack[i] && $urandom_range(0, 3) == 0) begin
          p_val[i] = WS'($urandom);
          p_req[i] = 1'b1;
        end
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
